// File: rtl/poly_audio_engine.sv
// Multi-voice step sequencer: per-channel pattern memory, one square-wave tone per channel,
// mixed by a first-order delta-sigma modulator onto a single 1-bit audio output.
module poly_audio_engine #(
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned HP_W       = 7,
    parameter int unsigned SYNTH_DIV  = 1024,
    parameter int unsigned STEP_TICKS = 2560,
    parameter int unsigned GATE_TICKS = 1280,
    localparam int unsigned IDX_W     = $clog2(DEPTH),
    localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [IDX_W-1:0] seq_len,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_chan,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [HP_W:0]    wr_data,
    output logic [IDX_W-1:0] step_idx,
    output logic             step_pulse,
    output logic             audio
);

    localparam int unsigned PRE_W = (SYNTH_DIV > 1) ? $clog2(SYNTH_DIV) : 1;
    localparam int unsigned SC_W  = $clog2(STEP_TICKS + 1);
    localparam int unsigned ACC_W = $clog2(2 * CHANNELS);

    logic [HP_W:0]       r_mem  [CHANNELS][DEPTH];
    logic [HP_W:0]       r_note [CHANNELS];
    logic [HP_W-1:0]     r_tcnt [CHANNELS];
    logic [CHANNELS-1:0] r_sq;
    logic [PRE_W-1:0]    r_presc;
    logic [SC_W-1:0]     r_step_ctr;
    logic [ACC_W-1:0]    r_acc;
    logic                r_run_d;

    logic                w_tick;
    logic                w_gate;
    logic                w_advance;
    logic                w_start;
    logic [IDX_W-1:0]    w_next_idx;
    logic [CHANNELS-1:0] w_active;
    logic [ACC_W-1:0]    w_sum;
    logic [ACC_W:0]      w_t;

    always_comb begin
        w_tick     = run && (r_presc == PRE_W'(SYNTH_DIV - 1));
        w_gate     = r_step_ctr < SC_W'(GATE_TICKS);
        w_advance  = w_tick && (r_step_ctr == SC_W'(STEP_TICKS - 1));
        w_start    = run && !r_run_d;
        w_next_idx = (step_idx >= seq_len) ? '0 : step_idx + IDX_W'(1);
        w_active   = '0;
        w_sum      = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_active[c] = r_note[c][HP_W] && (r_note[c][HP_W-1:0] != '0) && w_gate;
            w_sum       = w_sum + ACC_W'(r_sq[c]);
        end
        w_t = {1'b0, r_acc} + {1'b0, w_sum};
    end

    // Pattern memory is intentionally left out of reset so patterns survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_chan} < (CH_W + 1)'(CHANNELS))) begin
            r_mem[wr_chan][wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc    <= '0;
            r_step_ctr <= '0;
            r_acc      <= '0;
            r_sq       <= '0;
            r_run_d    <= 1'b0;
            step_idx   <= '0;
            step_pulse <= 1'b0;
            audio      <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_note[c] <= '0;
                r_tcnt[c] <= '0;
            end
        end else begin
            r_run_d <= run;
            if (!run) begin
                r_presc    <= '0;
                r_step_ctr <= '0;
                r_acc      <= '0;
                r_sq       <= '0;
                step_idx   <= '0;
                step_pulse <= 1'b0;
                audio      <= 1'b0;
                for (int c = 0; c < CHANNELS; c++) begin
                    r_tcnt[c] <= '0;
                end
            end else begin
                r_presc    <= w_tick ? '0 : r_presc + PRE_W'(1);
                step_pulse <= w_advance;
                if (w_tick) begin
                    r_step_ctr <= w_advance ? '0 : r_step_ctr + SC_W'(1);
                end
                if (w_advance) begin
                    step_idx <= w_next_idx;
                end
                // Fetch reads the pre-edge memory, so a same-cycle write is seen only next fetch.
                for (int c = 0; c < CHANNELS; c++) begin
                    if (w_start) begin
                        r_note[c] <= r_mem[c][0];
                    end else if (w_advance) begin
                        r_note[c] <= r_mem[c][w_next_idx];
                    end
                    if (w_advance || !w_active[c]) begin
                        r_tcnt[c] <= '0;
                        r_sq[c]   <= 1'b0;
                    end else if (w_tick) begin
                        if (r_tcnt[c] == r_note[c][HP_W-1:0] - HP_W'(1)) begin
                            r_tcnt[c] <= '0;
                            r_sq[c]   <= ~r_sq[c];
                        end else begin
                            r_tcnt[c] <= r_tcnt[c] + HP_W'(1);
                        end
                    end
                end
                if (w_t >= (ACC_W + 1)'(CHANNELS)) begin
                    audio <= 1'b1;
                    r_acc <= ACC_W'(w_t - (ACC_W + 1)'(CHANNELS));
                end else begin
                    audio <= 1'b0;
                    r_acc <= ACC_W'(w_t);
                end
            end
        end
    end

endmodule

// File: tb/tb_poly_audio_engine.sv
// Directed bench for poly_audio_engine with a queue scoreboard; expected audio traces
// are hand-derived per step kind for the small test configuration.
module tb_poly_audio_engine;

    localparam int unsigned CH = 2;
    localparam int unsigned DP = 4;
    localparam int unsigned HW = 4;
    localparam int unsigned SD = 4;
    localparam int unsigned ST = 8;
    localparam int unsigned GT = 4;
    localparam int          STEP_CLK = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic [1:0] seq_len = '0;
    logic       wr_en = 1'b0;
    logic [0:0] wr_chan = '0;
    logic [1:0] wr_addr = '0;
    logic [4:0] wr_data = '0;
    logic [1:0] step_idx;
    logic       step_pulse;
    logic       audio;

    always #5 clk = ~clk;

    poly_audio_engine #(
        .CHANNELS(CH), .DEPTH(DP), .HP_W(HW),
        .SYNTH_DIV(SD), .STEP_TICKS(ST), .GATE_TICKS(GT)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .seq_len(seq_len),
        .wr_en(wr_en), .wr_chan(wr_chan), .wr_addr(wr_addr), .wr_data(wr_data),
        .step_idx(step_idx), .step_pulse(step_pulse), .audio(audio)
    );

    typedef struct {
        string      tag;
        int         sel;
        logic [3:0] exp;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   e_cnt  = 0;
    int   len_m  = 0;
    int   kind_tab[8];

    // Kind 1: both voices hp=1 in phase; kind 2: one voice hp=2, other silent.
    function automatic logic [3:0] exp_audio(input int kind, input int l);
        logic hit;
        hit = 1'b0;
        if (kind == 1) hit = ((l >= 5) && (l <= 8)) || ((l >= 13) && (l <= 16));
        if (kind == 2) hit = (l == 10) || (l == 12) || (l == 14) || (l == 16);
        return {3'b000, hit};
    endfunction

    task automatic push(input string tag, input int sel, input logic [3:0] v);
        exp_t x;
        x.tag = tag;
        x.sel = sel;
        x.exp = v;
        sb.push_back(x);
    endtask

    task automatic check_now();
        exp_t       x;
        logic [3:0] obs;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            case (x.sel)
                0:       obs = {3'b000, audio};
                1:       obs = {2'b00, step_idx};
                default: obs = {3'b000, step_pulse};
            endcase
            checks++;
            assert (obs === x.exp) else begin
                errors++;
                $error("FAIL %s: observed=%0h expected=%0h", x.tag, obs, x.exp);
            end
        end
    endtask

    task automatic push_idle(input string tag);
        push({tag, "_audio"}, 0, 4'd0);
        push({tag, "_idx"}, 1, 4'd0);
        push({tag, "_pulse"}, 2, 4'd0);
    endtask

    task automatic run_edges(input int n, input string tag);
        int ka;
        int l;
        int ki;
        for (int i = 0; i < n; i++) begin
            e_cnt++;
            ka = (e_cnt - 1) / STEP_CLK;
            l  = ((e_cnt - 1) % STEP_CLK) + 1;
            ki = e_cnt / STEP_CLK;
            push({tag, "_audio"}, 0, exp_audio(kind_tab[ka], l));
            push({tag, "_idx"}, 1, 4'(ki % (len_m + 1)));
            push({tag, "_pulse"}, 2, 4'((e_cnt % STEP_CLK) == 0));
            @(posedge clk);
            #1;
            check_now();
        end
    endtask

    task automatic write_idle(input logic ch, input logic [1:0] addr, input logic [4:0] d);
        wr_en   = 1'b1;
        wr_chan = ch;
        wr_addr = addr;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic write_run(input logic ch, input logic [1:0] addr, input logic [4:0] d,
                             input string tag);
        wr_en   = 1'b1;
        wr_chan = ch;
        wr_addr = addr;
        wr_data = d;
        run_edges(1, tag);
        wr_en = 1'b0;
    endtask

    initial begin
        // Reset takes effect with no clock edge.
        #1 rst = 1'b1;
        #1;
        push_idle("t1_rst");
        check_now();
        #6 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_idle("t1_idle");
            @(posedge clk);
            #1;
            check_now();
        end

        // Single voice hp=2, seq_len=0: gated half-density audio, pulse every step.
        write_idle(1'b0, 2'd0, 5'b1_0010);
        write_idle(1'b1, 2'd0, 5'b0_0101);
        seq_len = 2'd0;
        len_m   = 0;
        for (int k = 0; k < 8; k++) kind_tab[k] = 2;
        run   = 1'b1;
        e_cnt = 0;
        run_edges(64, "t2");

        // Stop, then load all steps with in-phase hp=1 voices and seq_len=2.
        run = 1'b0;
        push_idle("t3_stop");
        @(posedge clk);
        #1;
        check_now();
        for (int a = 0; a < 4; a++) begin
            write_idle(1'b0, 2'(a), 5'b1_0001);
            write_idle(1'b1, 2'(a), 5'b1_0001);
        end
        seq_len = 2'd2;
        len_m   = 2;
        for (int k = 0; k < 8; k++) kind_tab[k] = 1;
        run   = 1'b1;
        e_cnt = 0;
        run_edges(166, "t3");

        // Mid-step reset while step 2 is sounding; restart must refetch retained pattern.
        #2 rst = 1'b1;
        #1;
        push_idle("t5_rst");
        check_now();
        #2 rst = 1'b0;
        for (int k = 0; k < 8; k++) kind_tab[k] = 1;
        kind_tab[2] = 2;
        e_cnt = 0;
        run_edges(33, "t5");

        // Writes during step 1: step 1 keeps its latched notes, step 2 picks up new data.
        write_run(1'b0, 2'd1, 5'b1_0010, "t6_w1");
        write_run(1'b0, 2'd2, 5'b1_0010, "t6_w2");
        write_run(1'b1, 2'd2, 5'b0_0000, "t6_w3");
        run_edges(40, "t6");

        // Dropping run mid-step silences and clears position on the next edge.
        run = 1'b0;
        push_idle("t6_stop");
        @(posedge clk);
        #1;
        check_now();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
